he_op_sequencer: RTL and testbench

HE_OP_SEQUENCER -- requirements
Module: he_op_sequencer

---
 rtl/he_op_sequencer.sv | 145 ++++++++++++++
 tb/tb_he_op_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/he_op_sequencer.sv
// rtl/he_op_sequencer.sv - HE operation sequencer: row/address stepping for ENCRYPT, DECRYPT, ADD, MULT
// Optional macro HE_SEQ_STALL_EN adds a stall input that pauses stepping in RUN.
module he_op_sequencer #(
  parameter int DIMENSION  = 10,
  parameter int BIG_N      = 30,
  parameter int ADDR_WIDTH = 16,
  parameter int ROW_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef HE_SEQ_STALL_EN
  input  logic                  stall,
`endif
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_opcode,
  input  logic [ADDR_WIDTH-1:0] op1_base,
  input  logic [ADDR_WIDTH-1:0] op2_base,
  input  logic [ADDR_WIDTH-1:0] res_base,
  output logic                  cmd_ready,
  output logic                  busy,
  output logic [1:0]            opcode_out,
  output logic [ADDR_WIDTH-1:0] op1_addr,
  output logic [ADDR_WIDTH-1:0] op2_addr,
  output logic [ADDR_WIDTH-1:0] res_addr,
  output logic                  op_select,
  output logic                  en,
  output logic [ROW_WIDTH-1:0]  row,
  output logic                  last,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [1:0] OP_ENC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b11;

  localparam logic [ROW_WIDTH-1:0] LAST_ENC = ROW_WIDTH'(BIG_N - 1);
  localparam logic [ROW_WIDTH-1:0] LAST_DEC = ROW_WIDTH'(DIMENSION - 1);
  localparam logic [ROW_WIDTH-1:0] LAST_CT  = ROW_WIDTH'(DIMENSION);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ROW_WIDTH-1:0]  ROW_ONE  = ROW_WIDTH'(1);

  state_t                  state_q, state_d;
  logic                    op_sel_q, op_sel_d;
  logic [1:0]              opcode_d;
  logic [ADDR_WIDTH-1:0]   op1_d, op2_d, res_d;
  logic [ROW_WIDTH-1:0]    row_d;
  logic [ROW_WIDTH-1:0]    last_row;
  logic                    stall_w;
  logic                    is_mult;
  logic                    final_row;
  logic                    run;

`ifdef HE_SEQ_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  always_comb begin
    last_row = LAST_CT;
    case (opcode_out)
      OP_ENC:  last_row = LAST_ENC;
      OP_DEC:  last_row = LAST_DEC;
      default: last_row = LAST_CT;
    endcase
  end

  assign is_mult   = (opcode_out == OP_MULT);
  assign final_row = (row == last_row);
  assign run       = (state_q == S_RUN);

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = run || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign en        = run && !stall_w;
  assign op_select = run && op_sel_q;
  // MULT finishes a row only on its second (op_select=1) phase
  assign last      = en && final_row && (!is_mult || op_sel_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_sel_q   <= 1'b0;
      opcode_out <= '0;
      op1_addr   <= '0;
      op2_addr   <= '0;
      res_addr   <= '0;
      row        <= '0;
    end else begin
      state_q    <= state_d;
      op_sel_q   <= op_sel_d;
      opcode_out <= opcode_d;
      op1_addr   <= op1_d;
      op2_addr   <= op2_d;
      res_addr   <= res_d;
      row        <= row_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_sel_d = op_sel_q;
    opcode_d = opcode_out;
    op1_d    = op1_addr;
    op2_d    = op2_addr;
    res_d    = res_addr;
    row_d    = row;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          opcode_d = cmd_opcode;
          op1_d    = op1_base;
          op2_d    = op2_base;
          res_d    = res_base;
          row_d    = '0;
          op_sel_d = 1'b0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (!stall_w) begin
          if (is_mult && !op_sel_q) begin
            op_sel_d = 1'b1;
          end else begin
            op_sel_d = 1'b0;
            // addresses hold on the final step so they keep their last used value
            if (final_row) begin
              state_d = S_DONE;
            end else begin
              row_d = row + ROW_ONE;
              op1_d = op1_addr + ADDR_ONE;
              op2_d = op2_addr + ADDR_ONE;
              res_d = res_addr + ADDR_ONE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_he_op_sequencer.sv
// tb/tb_he_op_sequencer.sv - self-checking bench for he_op_sequencer against a per-step reference model
module tb_he_op_sequencer;

  logic        clk;
  logic        rst;
`ifdef HE_SEQ_STALL_EN
  logic        stall;
`endif
  logic        cmd_valid;
  logic [1:0]  cmd_opcode;
  logic [15:0] op1_base, op2_base, res_base;
  logic        cmd_ready, busy, op_select, en, last, done;
  logic [1:0]  opcode_out;
  logic [15:0] op1_addr, op2_addr, res_addr;
  logic [5:0]  row;

  int checks = 0;
  int errors = 0;

  he_op_sequencer dut (
    .clk(clk), .rst(rst),
`ifdef HE_SEQ_STALL_EN
    .stall(stall),
`endif
    .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode),
    .op1_base(op1_base), .op2_base(op2_base), .res_base(res_base),
    .cmd_ready(cmd_ready), .busy(busy), .opcode_out(opcode_out),
    .op1_addr(op1_addr), .op2_addr(op2_addr), .res_addr(res_addr),
    .op_select(op_select), .en(en), .row(row), .last(last), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rows_for(input logic [1:0] op);
    case (op)
      2'b00:   return 30;
      2'b01:   return 10;
      default: return 11;
    endcase
  endfunction

  // Runs one command from an idle cycle through its done pulse, checking every step.
  task automatic run_cmd(input logic [1:0] op, input logic [15:0] b1, input logic [15:0] b2,
                         input logic [15:0] b3, input bit intrude, input int stall_at,
                         input int stall_len);
    int r_cnt, s_cnt, r, p;
    logic [15:0] e1, e2, e3;
    r_cnt = rows_for(op);
    s_cnt = (op == 2'b11) ? 2 * r_cnt : r_cnt;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL accept_ready got %b want 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_opcode = op; op1_base = b1; op2_base = b2; res_base = b3;
    for (int i = 0; i < s_cnt; i++) begin
      @(negedge clk);
      if (intrude) begin
        cmd_valid = 1'b1; cmd_opcode = 2'($urandom); op1_base = 16'($urandom);
        op2_base = 16'($urandom); res_base = 16'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      r = (op == 2'b11) ? i / 2 : i;
      p = (op == 2'b11) ? i % 2 : 0;
      e1 = b1 + 16'(r); e2 = b2 + 16'(r); e3 = b3 + 16'(r);
`ifdef HE_SEQ_STALL_EN
      if (i == stall_at) begin
        for (int j = 0; j < stall_len; j++) begin
          stall = 1'b1; #1;
          checks++;
          if (en !== 1'b0 || last !== 1'b0 || row !== 6'(r) || op_select !== 1'(p)) begin
            errors++;
            $display("FAIL stall_hold step %0d en=%b last=%b row=%0d sel=%b want en=0 last=0 row=%0d sel=%0d",
                     i, en, last, row, op_select, r, p);
          end
          @(negedge clk);
        end
        stall = 1'b0;
      end
`endif
      #1;
      checks++;
      if (en !== 1'b1 || row !== 6'(r) || op_select !== 1'(p) || last !== (i == s_cnt - 1)
          || op1_addr !== e1 || op2_addr !== e2 || res_addr !== e3 || opcode_out !== op
          || busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL step op=%0d i=%0d got en=%b row=%0d sel=%b last=%b a=%h/%h/%h opc=%0d busy=%b rdy=%b done=%b want row=%0d sel=%0d last=%0d a=%h/%h/%h",
                 op, i, en, row, op_select, last, op1_addr, op2_addr, res_addr, opcode_out,
                 busy, cmd_ready, done, r, p, (i == s_cnt - 1), e1, e2, e3);
      end
    end
    @(negedge clk);
    if (!intrude) cmd_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || en !== 1'b0 || last !== 1'b0 || op_select !== 1'b0 || busy !== 1'b1
        || cmd_ready !== 1'b0 || opcode_out !== op) begin
      errors++;
      $display("FAIL done_cycle op=%0d got done=%b en=%b last=%b sel=%b busy=%b rdy=%b want 1 0 0 0 1 0",
               op, done, en, last, op_select, busy, cmd_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b1; cmd_opcode = 2'b11;
    op1_base = 16'h1234; op2_base = 16'h5678; res_base = 16'h9abc;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || en !== 1'b0 || done !== 1'b0 || last !== 1'b0
        || op_select !== 1'b0 || row !== 6'd0 || opcode_out !== 2'd0 || op1_addr !== 16'd0
        || op2_addr !== 16'd0 || res_addr !== 16'd0) begin
      errors++;
      $display("FAIL reset_state rdy=%b busy=%b en=%b done=%b row=%0d opc=%0d a=%h/%h/%h want rdy=1 rest 0",
               cmd_ready, busy, en, done, row, opcode_out, op1_addr, op2_addr, res_addr);
    end
    rst = 1'b0; cmd_valid = 1'b0;
  endtask

  task automatic test_add;
    run_cmd(2'b10, 16'h0100, 16'h0200, 16'h0300, 1'b0, -1, 0);
  endtask

  task automatic test_mult;
    run_cmd(2'b11, 16'h0000, 16'h0040, 16'h0080, 1'b0, -1, 0);
  endtask

  task automatic test_encrypt_wrap;
    run_cmd(2'b00, 16'h0010, 16'hFFF0, 16'hFFFE, 1'b0, -1, 0);
  endtask

  task automatic test_back_to_back;
    run_cmd(2'b10, 16'h0500, 16'h0600, 16'h0700, 1'b1, -1, 0);
    cmd_opcode = 2'b01; op1_base = 16'h0A00; op2_base = 16'h0B00; res_base = 16'h0C00;
    run_cmd(2'b01, 16'h0A00, 16'h0B00, 16'h0C00, 1'b0, -1, 0);
  endtask

  task automatic test_reset_abort;
    bit seen_done;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = 2'b01; op1_base = 16'h0020; op2_base = 16'h0030; res_base = 16'h0040;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    checks++;
    if (row !== 6'd4 || en !== 1'b1) begin
      errors++; $display("FAIL abort_pre row=%0d en=%b want row=4 en=1", row, en);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || en !== 1'b0 || done !== 1'b0 || row !== 6'd0
        || opcode_out !== 2'd0 || op1_addr !== 16'd0 || op2_addr !== 16'd0 || res_addr !== 16'd0) begin
      errors++;
      $display("FAIL abort_state rdy=%b busy=%b en=%b done=%b row=%0d opc=%0d a=%h want rdy=1 rest 0",
               cmd_ready, busy, en, done, row, opcode_out, op1_addr);
    end
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || en === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin errors++; $display("FAIL abort_no_done got activity=1 want 0"); end
  endtask

`ifdef HE_SEQ_STALL_EN
  task automatic test_stall;
    run_cmd(2'b10, 16'h0100, 16'h0200, 16'h0300, 1'b0, 5, 3);
    run_cmd(2'b11, 16'h0007, 16'h0008, 16'h0009, 1'b0, 9, 2);
  endtask
`endif

  task automatic test_random;
    for (int k = 0; k < 8; k++) begin
      run_cmd(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, -1, 0);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 2'b00;
    op1_base = '0; op2_base = '0; res_base = '0;
`ifdef HE_SEQ_STALL_EN
    stall = 1'b0;
`endif
    test_reset();
    test_add();
    test_mult();
    test_encrypt_wrap();
    test_back_to_back();
    test_reset_abort();
`ifdef HE_SEQ_STALL_EN
    test_stall();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
